mesh_term_rx: RTL and testbench
===============================

Name: mesh_term_rx

Overview:
- Terminal sink for one mesh_gnrtr output port. Drains the port's pndng/pop/data_out interface and decodes each packet header.
- Checks each packet's destination against the terminal's own row/column, or broadcast.
- Buffers decoded packets and hands them to a local consumer over valid/ready.
- One instance per terminal; it replaces the bench agent's pop side in synthesizable designs.

Parameters:
- pckg_sz, 41, packet width in bits.
- MY_ROW, 0, row address of this terminal (4-bit).
- MY_COL, 0, column address of this terminal (4-bit).
- bdcst, 8'hFF, next-jump value that marks a broadcast packet.
- BUF_DEPTH, 4, local buffer depth; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pndng  in  1  mesh output FIFO non-empty.
- data_out  in  pckg_sz  mesh output FIFO head.
- pop  out  1  one-cycle pulse that dequeues the mesh output FIFO head.
- pkt_valid  out  1  decoded packet available.
- pkt_ready  in  1  consumer accepts the packet when pkt_valid && pkt_ready.
- pkt_data  out  pckg_sz  full captured packet.
- pkt_bcast  out  1  the packet at the buffer head is a broadcast.
- pkt_misroute  out  1  the packet at the buffer head has a wrong destination.
- rx_count  out  CNT_W  packets popped since reset.
- err_count  out  CNT_W  misrouted packets since reset.
- err_sticky  out  1  set on the first misroute; cleared only by reset.

Behaviour:
- Packet fields:
  - [pckg_sz-1 -: 8] next-jump.
  - [pckg_sz-9 -: 4] target row.
  - [pckg_sz-13 -: 4] target column.
  - [pckg_sz-17] mode.
  - Remaining low bits: payload.
- Reset (synchronous): all outputs 0, buffer empty, FSM in IDLE, counters 0.
- FSM states and transitions:
  - IDLE: if pndng && buffer not full, go to POP.
  - POP: assert pop for exactly one cycle. Capture data_out on this same clock edge and push it to the buffer. Go to SETTLE.
  - SETTLE: pop=0 for one cycle to allow pndng/data_out to update. Go to IDLE.
- Throughput and latency:
  - Maximum throughput is one packet per 3 cycles.
  - Latency: pndng high in IDLE -> pop at cycle +1 -> pkt_valid at cycle +2 if the buffer was empty.
- pop is never asserted when pndng=0 or when the buffer is full.
- If pndng drops while the FSM is in POP, the pop still completes. The mesh guarantees data is stable until popped, so no abort is needed.
- Decode at capture time:
  - bcast = (next-jump == bdcst).
  - misroute = !bcast && (target row != MY_ROW || target column != MY_COL).
  - Both flags are stored alongside the packet.
- Buffer behaviour:
  - FIFO, BUF_DEPTH entries. pkt_* outputs show the head (first-word-fall-through).
  - Simultaneous push and pop when full is impossible, because the FSM checks "not full" in IDLE.
  - Simultaneous push and pop when non-full: count is unchanged and the head advances.
- Counters:
  - rx_count increments on every POP cycle.
  - err_count increments on every misrouted capture.
  - Both saturate at all-ones and never wrap.
- err_sticky is set on the first misroute and held until reset.
- Reset asserted mid-operation (any state) returns the block to IDLE next cycle. Buffer contents are discarded and pop is deasserted.

Decomposition:
- Shared package mesh_term_pkg holds:
  - field offset localparams (NXT_MSB, ROW_MSB, COL_MSB, MODE_BIT);
  - a state enum {IDLE, POP, SETTLE};
  - a typedef for a buffer entry {bcast, misroute, data}.
- Sub-module mesh_term_buf: synchronous FWFT FIFO of entry type, with full and empty flags.

Test Plan:
- MY_ROW=1, MY_COL=2. Hold pndng=1 with data_out = {8'h12, 4'h1, 4'h2, 1'b0, 24'hABCDEF}, pkt_ready=1 -> pop is a 1-cycle pulse; one cycle later pkt_valid=1 and pkt_data matches; pkt_misroute=0; rx_count=1.
- Broadcast packet {8'hFF, 4'h3, 4'h3, ...} -> pkt_bcast=1, pkt_misroute=0, err_count=0.
- Packet addressed to row 2, column 2 -> pkt_misroute=1, err_count=1, err_sticky=1 and still 1 after 10 cycles.
- pkt_ready=0 with pndng held high -> exactly BUF_DEPTH=4 pops occur, then pop stays 0. Raise pkt_ready -> popping resumes with at least 3 cycles between pop pulses.
- Assert reset during the POP state with 2 packets buffered -> next cycle pkt_valid=0, pop=0, rx_count=0, FSM in IDLE.
- Back-to-back stream of 20 packets with pndng continuously high -> pop pulses spaced exactly 3 cycles apart; output order matches input order; rx_count=20.

Source files
------------

// File: rtl/mesh_term_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesh_term_pkg
// Description : Shared definitions for the mesh terminal receiver: packet
//               field offsets, receive FSM states and buffer entry flags.
// Revision    : 1.0 - initial release
// ============================================================================
package mesh_term_pkg;

  // Field positions are given as distances below the packet width, so that
  // a field's MSB sits at bit (pckg_sz - <offset>) for any packet size.
  localparam int NXT_MSB  = 1;   // next-jump byte
  localparam int ROW_MSB  = 9;   // target row nibble
  localparam int COL_MSB  = 13;  // target column nibble
  localparam int MODE_BIT = 17;  // mode bit

  localparam int NXT_W  = 8;
  localparam int ADDR_W = 4;

  // Receive sequencer: one pop, then one idle cycle for the mesh FIFO head
  // to settle before pndng is trusted again.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Decode flags stored next to each captured packet. A buffer entry is
  // {bcast, misroute, data}, with the flags in the top two bits.
  typedef struct packed {
    logic bcast;
    logic misroute;
  } entry_flags_t;

endpackage
`default_nettype wire

// File: rtl/mesh_term_buf.sv
`default_nettype none
// ============================================================================
// Module      : mesh_term_buf
// Description : Synchronous first-word-fall-through FIFO holding decoded
//               packet entries. Read data is forced to zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_term_buf #(
  parameter int W     = 43,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_entry,
  input  logic         pop,
  output logic [W-1:0] rd_entry,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  w_level;
  logic         w_wr_en;
  logic         w_rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign empty   = (w_level == '0);
  assign full    = (w_level == (AW+1)'(DEPTH));
  assign w_wr_en = push && !full;
  assign w_rd_en = pop && !empty;

  // Head of the queue is visible without a read request; zero when empty.
  assign rd_entry = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  // Read and write pointer advance; reset discards all buffered entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesh_term_rx.sv
`default_nettype none
// ============================================================================
// Module      : mesh_term_rx
// Description : Terminal sink for one mesh output port. Pops packets from the
//               mesh FIFO, flags broadcasts and misroutes against this
//               terminal's row/column, buffers them and presents them to a
//               local consumer over valid/ready. Keeps receive statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_term_rx
  import mesh_term_pkg::*;
#(
  parameter int         pckg_sz   = 41,
  parameter int         MY_ROW    = 0,
  parameter int         MY_COL    = 0,
  parameter logic [7:0] bdcst     = 8'hFF,
  parameter int         BUF_DEPTH = 4,
  parameter int         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               pkt_valid,
  input  logic               pkt_ready,
  output logic [pckg_sz-1:0] pkt_data,
  output logic               pkt_bcast,
  output logic               pkt_misroute,
  output logic [CNT_W-1:0]   rx_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               err_sticky
);

  localparam int EW = pckg_sz + 2;

  state_t            r_state;
  state_t            w_next;
  logic [NXT_W-1:0]  w_nxt;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic              w_bcast;
  logic              w_misroute;
  logic              w_full;
  logic              w_empty;
  logic              w_head_pop;
  logic [EW-1:0]     w_wr_entry;
  logic [EW-1:0]     w_rd_entry;
  entry_flags_t      w_head_flags;

  // Header decode of the mesh FIFO head; only meaningful on the POP cycle.
  assign w_nxt      = data_out[pckg_sz-NXT_MSB -: NXT_W];
  assign w_row      = data_out[pckg_sz-ROW_MSB -: ADDR_W];
  assign w_col      = data_out[pckg_sz-COL_MSB -: ADDR_W];
  assign w_bcast    = (w_nxt == bdcst);
  assign w_misroute = !w_bcast &&
                      ((w_row != ADDR_W'(MY_ROW)) || (w_col != ADDR_W'(MY_COL)));

  // Next-state and pop decode. Fullness is only checked in IDLE, so the
  // push in POP can never find the buffer full.
  always_comb begin
    w_next = r_state;
    pop    = 1'b0;
    case (r_state)
      IDLE: begin
        if (pndng && !w_full) begin
          w_next = POP;
        end
      end
      POP: begin
        pop    = 1'b1;
        w_next = SETTLE;
      end
      SETTLE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_wr_entry = {w_bcast, w_misroute, data_out};
  assign w_head_pop = pkt_valid && pkt_ready;

  mesh_term_buf #(
    .W     (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (pop),
    .wr_entry (w_wr_entry),
    .pop      (w_head_pop),
    .rd_entry (w_rd_entry),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign {w_head_flags, pkt_data} = w_rd_entry;
  assign pkt_valid    = !w_empty;
  assign pkt_bcast    = w_head_flags.bcast;
  assign pkt_misroute = w_head_flags.misroute;

  // Saturating receive/error counters and the sticky misroute flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_count   <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (pop) begin
      if (!(&rx_count)) begin
        rx_count <= rx_count + CNT_W'(1);
      end
      if (w_misroute) begin
        err_sticky <= 1'b1;
        if (!(&err_count)) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_term_rx
// Description : Directed self-checking bench for mesh_term_rx (row 1, col 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_term_rx;

  localparam int PW = 41;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          pndng;
  logic [PW-1:0] data_out;
  logic          pop;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [PW-1:0] pkt_data;
  logic          pkt_bcast;
  logic          pkt_misroute;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] err_count;
  logic          err_sticky;

  int total = 0;
  int bad   = 0;

  mesh_term_rx #(
    .pckg_sz   (PW),
    .MY_ROW    (1),
    .MY_COL    (2),
    .bdcst     (8'hFF),
    .BUF_DEPTH (4),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pndng        (pndng),
    .data_out     (data_out),
    .pop          (pop),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data),
    .pkt_bcast    (pkt_bcast),
    .pkt_misroute (pkt_misroute),
    .rx_count     (rx_count),
    .err_count    (err_count),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [PW-1:0] P_OK    = {8'h12, 4'h1, 4'h2, 1'b0, 24'hABCDEF};
  localparam logic [PW-1:0] P_BCAST = {8'hFF, 4'h3, 4'h3, 1'b1, 24'h123456};
  localparam logic [PW-1:0] P_BAD   = {8'h12, 4'h2, 4'h2, 1'b0, 24'h0F0F0F};

  task automatic apply_reset();
    reset     = 1'b1;
    pndng     = 1'b0;
    pkt_ready = 1'b0;
    data_out  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    @(negedge clk);
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b want 0", pop); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pkt_valid); end
    total++; if (pkt_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", pkt_data); end
    total++; if (rx_count !== '0 || err_count !== '0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL reset_counters: got rx=%0d err=%0d sticky=%b want 0/0/0", rx_count, err_count, err_sticky);
    end
    reset = 1'b0;
    @(negedge clk);
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL reset_idle_pop: got %b want 0", pop); end
  endtask

  task automatic test_single();
    data_out  = P_OK;
    pndng     = 1'b1;
    pkt_ready = 1'b1;
    @(negedge clk);
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL single_pop_latency: got %b want 1", pop); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL single_valid_early: got %b want 0", pkt_valid); end
    pndng = 1'b0;
    @(negedge clk);
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL single_pop_pulse: got %b want 0", pop); end
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", pkt_valid); end
    total++; if (pkt_data !== P_OK) begin bad++; $display("FAIL single_data: got %h want %h", pkt_data, P_OK); end
    total++; if (pkt_misroute !== 1'b0 || pkt_bcast !== 1'b0) begin
      bad++; $display("FAIL single_flags: got bcast=%b mis=%b want 0/0", pkt_bcast, pkt_misroute);
    end
    total++; if (rx_count !== 16'd1) begin bad++; $display("FAIL single_rx_count: got %0d want 1", rx_count); end
    @(negedge clk);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL single_consumed: got %b want 0", pkt_valid); end
  endtask

  task automatic test_bcast();
    int n;
    data_out = P_BCAST;
    pndng    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (pop !== 1'b1 && n < 10);
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL bcast_pop_timeout: got %b want 1", pop); end
    pndng = 1'b0;
    @(negedge clk);
    total++; if (pkt_valid !== 1'b1 || pkt_data !== P_BCAST) begin
      bad++; $display("FAIL bcast_data: got v=%b %h want 1 %h", pkt_valid, pkt_data, P_BCAST);
    end
    total++; if (pkt_bcast !== 1'b1 || pkt_misroute !== 1'b0) begin
      bad++; $display("FAIL bcast_flags: got bcast=%b mis=%b want 1/0", pkt_bcast, pkt_misroute);
    end
    total++; if (err_count !== 16'd0 || rx_count !== 16'd2) begin
      bad++; $display("FAIL bcast_counts: got err=%0d rx=%0d want 0/2", err_count, rx_count);
    end
    @(negedge clk);
  endtask

  task automatic test_misroute();
    int n;
    data_out = P_BAD;
    pndng    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (pop !== 1'b1 && n < 10);
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL misroute_pop_timeout: got %b want 1", pop); end
    pndng = 1'b0;
    @(negedge clk);
    total++; if (pkt_misroute !== 1'b1 || pkt_bcast !== 1'b0) begin
      bad++; $display("FAIL misroute_flags: got mis=%b bcast=%b want 1/0", pkt_misroute, pkt_bcast);
    end
    total++; if (err_count !== 16'd1 || err_sticky !== 1'b1) begin
      bad++; $display("FAIL misroute_err: got err=%0d sticky=%b want 1/1", err_count, err_sticky);
    end
    repeat (10) @(negedge clk);
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL misroute_sticky_hold: got %b want 1", err_sticky); end
    total++; if (rx_count !== 16'd3 || err_count !== 16'd1) begin
      bad++; $display("FAIL misroute_counts: got rx=%0d err=%0d want 3/1", rx_count, err_count);
    end
  endtask

  task automatic test_backpressure();
    int pops;
    int seen;
    int last;
    int gap_min;
    int n;
    pkt_ready = 1'b0;
    data_out  = P_OK;
    pndng     = 1'b1;
    pops      = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (pop === 1'b1) pops++;
    end
    total++; if (pops != 4) begin bad++; $display("FAIL bp_pop_count: got %0d want 4", pops); end
    total++; if (pop !== 1'b0 || pkt_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stalled: got pop=%b valid=%b want 0/1", pop, pkt_valid);
    end
    total++; if (rx_count !== 16'd7) begin bad++; $display("FAIL bp_rx_count: got %0d want 7", rx_count); end
    pkt_ready = 1'b1;
    seen      = 0;
    last      = -1;
    gap_min   = 1000;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (pop === 1'b1) begin
        if (last >= 0 && (c - last) < gap_min) gap_min = c - last;
        last = c;
        seen++;
      end
    end
    total++; if (seen < 3) begin bad++; $display("FAIL bp_resume: got %0d pops want >=3", seen); end
    total++; if (gap_min < 3) begin bad++; $display("FAIL bp_spacing: got min gap %0d want >=3", gap_min); end
    pndng = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (pkt_valid !== 1'b0 && n < 20);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", pkt_valid); end
  endtask

  task automatic test_reset_mid();
    int pops;
    pkt_ready = 1'b0;
    data_out  = P_OK;
    pndng     = 1'b1;
    pops      = 0;
    for (int c = 0; c < 30 && pops < 3; c++) begin
      @(negedge clk);
      if (pop === 1'b1) pops++;
    end
    // Now in POP with two packets already buffered.
    total++; if (pops != 3) begin bad++; $display("FAIL rstmid_reach_pop: got %0d pops want 3", pops); end
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL rstmid_buffered: got %b want 1", pkt_valid); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (pkt_valid !== 1'b0 || pop !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs: got valid=%b pop=%b want 0/0", pkt_valid, pop);
    end
    total++; if (rx_count !== '0 || err_count !== '0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL rstmid_counters: got rx=%0d err=%0d sticky=%b want 0/0/0", rx_count, err_count, err_sticky);
    end
    reset = 1'b0;
    @(negedge clk);
    // From IDLE with pndng high the pop appears exactly one cycle later.
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL rstmid_idle: got pop=%b want 1", pop); end
    pndng     = 1'b0;
    pkt_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] pkts [20];
    int idx;
    int out_idx;
    int last;
    int pops;
    bit adv;
    for (int i = 0; i < 20; i++) begin
      pkts[i] = {8'h12, 4'h1, 4'h2, i[0], 24'(i * 24'h010203 + 5)};
    end
    apply_reset();
    idx       = 0;
    out_idx   = 0;
    last      = -1;
    pops      = 0;
    adv       = 1'b0;
    pkt_ready = 1'b1;
    data_out  = pkts[0];
    pndng     = 1'b1;
    for (int c = 0; c < 200 && out_idx < 20; c++) begin
      @(negedge clk);
      if (adv) begin
        idx++;
        adv      = 1'b0;
        pndng    = (idx < 20);
        data_out = (idx < 20) ? pkts[idx] : '0;
      end
      if (pop === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (c - last != 3) begin bad++; $display("FAIL b2b_spacing: got gap %0d want 3 at pop %0d", c - last, pops); end
        end
        last = c;
        pops++;
        adv = 1'b1;
      end
      if (pkt_valid === 1'b1 && out_idx < 20) begin
        total++;
        if (pkt_data !== pkts[out_idx]) begin
          bad++; $display("FAIL b2b_order: got %h want %h at index %0d", pkt_data, pkts[out_idx], out_idx);
        end
        out_idx++;
      end
    end
    total++; if (out_idx != 20) begin bad++; $display("FAIL b2b_delivered: got %0d want 20", out_idx); end
    total++; if (pops != 20) begin bad++; $display("FAIL b2b_pops: got %0d want 20", pops); end
    total++; if (rx_count !== 16'd20 || err_count !== 16'd0) begin
      bad++; $display("FAIL b2b_counts: got rx=%0d err=%0d want 20/0", rx_count, err_count);
    end
  endtask

  initial begin
    reset     = 1'b1;
    pndng     = 1'b0;
    pkt_ready = 1'b0;
    data_out  = '0;
    test_reset();
    test_single();
    test_bcast();
    test_misroute();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
